// File: rtl/mcoc_uart_rx_abd.sv
// UART 8N1 receiver with automatic baud detection, memory-mapped (ctl/baud/rdat/bres).
// Latency: a byte is posted one clk after its stop-bit mid-sample; reads are combinational.
// Backpressure: none. An unread byte is overwritten by the next one, and ORER records the loss.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   rxd             serial input (asynchronous, idle high)
//   adr/cs/rd/wr    register window: 0x0 ctl, 0x2 baud, 0x6 rdat, 0xe bres
//   wdat / rdat     write data / read data (rdat is 0 unless cs&rd)
//   irq             RAVL & RIE
module mcoc_uart_rx_abd #(
   parameter logic [15:0] RST_BAUD = 16'h09c3,
   parameter int          BRD_MIN  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rxd,
   input  logic [3:0]  adr,
   input  logic        cs,
   input  logic        rd,
   input  logic        wr,
   input  logic [15:0] wdat,
   output logic [15:0] rdat,
   output logic        irq
);

   localparam logic [15:0] BRD_MIN_W = 16'(BRD_MIN);

   localparam logic [3:0] ADR_CTL  = 4'h0;
   localparam logic [3:0] ADR_BAUD = 4'h2;
   localparam logic [3:0] ADR_RDAT = 4'h6;
   localparam logic [3:0] ADR_BRES = 4'he;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } state_t;

   // ------------------------------------------------------------------
   // Input synchronizer and edge detection
   // ------------------------------------------------------------------
   logic rx_meta;
   logic rxs;
   logic rxs_d;

   // Reset to the idle level so that leaving reset never looks like a start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
         rxs_d   <= 1'b1;
      end else begin
         rx_meta <= rxd;
         rxs     <= rx_meta;
         rxs_d   <= rxs;
      end
   end

   logic rx_fall;
   logic rx_rise;

   assign rx_fall = rxs_d & ~rxs;
   assign rx_rise = ~rxs_d & rxs;

   // ------------------------------------------------------------------
   // Register access decode
   // ------------------------------------------------------------------
   logic wr_ctl;
   logic wr_baud;
   logic rd_rdat;

   assign wr_ctl  = cs & wr & (adr == ADR_CTL);
   assign wr_baud = cs & wr & (adr == ADR_BAUD);
   assign rd_rdat = cs & rd & (adr == ADR_RDAT);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic        rxe;
   logic        rie;
   logic        ravl;
   logic        orer;
   logic        brdf;
   logic        frer;
   logic [15:0] baud;
   logic [15:0] rx_data;
   logic [15:0] bres;
   logic [15:0] lw;

   state_t      state;
   logic [15:0] tmr;
   logic [2:0]  bitcnt;
   logic [7:0]  shreg;

   // ------------------------------------------------------------------
   // Receiver FSM
   // ------------------------------------------------------------------
   logic tmr_zero;
   logic deliver;

   assign tmr_zero = (tmr == 16'h0000);
   // Stop-bit sample point. Dropping RXE takes priority, so an aborted frame is never posted.
   assign deliver  = rxe & (state == ST_STOP) & tmr_zero;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         tmr    <= 16'h0000;
         bitcnt <= 3'd0;
         shreg  <= 8'h00;
      end else if (!rxe) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (rx_fall) begin
                  // Half a bit time places every later sample near mid-bit.
                  tmr   <= baud >> 1;
                  state <= ST_START;
               end
            end
            ST_START: begin
               if (tmr_zero) begin
                  if (rxs) begin
                     state <= ST_IDLE;   // line is high again, so this was a false start
                  end else begin
                     tmr    <= baud;
                     bitcnt <= 3'd0;
                     state  <= ST_DATA;
                  end
               end else begin
                  tmr <= tmr - 16'd1;
               end
            end
            ST_DATA: begin
               if (tmr_zero) begin
                  // The line sends LSB first, so shift in from the top. After 8 bits the
                  // first bit has reached bit 0.
                  shreg <= {rxs, shreg[7:1]};
                  tmr   <= baud;
                  if (bitcnt == 3'd7) begin
                     state <= ST_STOP;
                  end else begin
                     bitcnt <= bitcnt + 3'd1;
                  end
               end else begin
                  tmr <= tmr - 16'd1;
               end
            end
            ST_STOP: begin
               if (tmr_zero) begin
                  state <= ST_IDLE;
               end else begin
                  tmr <= tmr - 16'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Baud-rate detector: width of each low pulse on the line
   // ------------------------------------------------------------------
   logic [15:0] lw_m1;
   logic        detect;

   assign lw_m1  = lw - 16'd1;
   // A pulse of at least BRD_MIN clocks that is shorter than any pulse seen so far.
   // Because lw >= BRD_MIN here, lw_m1 cannot wrap.
   assign detect = rx_rise & (lw >= BRD_MIN_W) & (lw_m1 < bres);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lw <= 16'h0000;
      end else if (rx_rise) begin
         lw <= 16'h0000;
      end else if (!rxs && (lw != 16'hffff)) begin
         lw <= lw + 16'd1;
      end
   end

   // ------------------------------------------------------------------
   // Control, status and data registers
   // ------------------------------------------------------------------
   // In every sticky flag, a hardware set takes priority over a write-1-to-clear in the same
   // cycle, so an event is never lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxe     <= 1'b0;
         rie     <= 1'b0;
         ravl    <= 1'b0;
         orer    <= 1'b0;
         brdf    <= 1'b0;
         frer    <= 1'b0;
         baud    <= RST_BAUD;
         rx_data <= 16'h0000;
         bres    <= 16'hffff;
      end else begin
         if (wr_ctl) begin
            rxe <= wdat[1];
            rie <= wdat[0];
         end

         if (wr_baud) begin
            baud <= wdat;
         end

         // A byte posted in the same cycle as an rdat read keeps RAVL set.
         if (deliver) begin
            ravl    <= 1'b1;
            rx_data <= {8'h00, shreg};
         end else if (rd_rdat) begin
            ravl <= 1'b0;
         end

         // Overrun only when the previous byte is still unread and no read takes it this cycle.
         if (deliver && ravl && !rd_rdat) begin
            orer <= 1'b1;
         end else if (wr_ctl && wdat[6]) begin
            orer <= 1'b0;
         end

         // A low stop bit flags the frame, but the byte is still posted.
         if (deliver && !rxs) begin
            frer <= 1'b1;
         end else if (wr_ctl && wdat[4]) begin
            frer <= 1'b0;
         end

         // Clearing BRDF also restarts the measurement, unless a detection lands in the same cycle.
         if (detect) begin
            brdf <= 1'b1;
            bres <= lw_m1;
         end else if (wr_ctl && wdat[5]) begin
            brdf <= 1'b0;
            bres <= 16'hffff;
         end
      end
   end

   // ------------------------------------------------------------------
   // Read mux and interrupt
   // ------------------------------------------------------------------
   logic [15:0] ctl_word;
   logic [15:0] rd_mux;

   assign ctl_word = {8'h00, ravl, orer, brdf, frer, 2'b00, rxe, rie};

   always_comb begin
      rd_mux = 16'h0000;
      case (adr)
         ADR_CTL:  rd_mux = ctl_word;
         ADR_BAUD: rd_mux = baud;
         ADR_RDAT: rd_mux = rx_data;
         ADR_BRES: rd_mux = bres;
         default:  rd_mux = 16'h0000;
      endcase
   end

   assign rdat = (cs && rd) ? rd_mux : 16'h0000;
   assign irq  = ravl & rie;

endmodule
